// File: rtl/dbg_pkg.sv
// Shared command codes, FSM states and error response words for the debug command responder.
// Write commands (MEM_WR, REG_WR) echo their write data as the response word.
package dbg_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CMD_W   = 8;
    localparam int unsigned RF_AW   = 5;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP    = 8'h00,
        CMD_HALT   = 8'h01,
        CMD_RESUME = 8'h02,
        CMD_RESET  = 8'h03,
        CMD_MEM_RD = 8'h04,
        CMD_MEM_WR = 8'h05,
        CMD_REG_RD = 8'h06,
        CMD_REG_WR = 8'h07,
        CMD_STEP   = 8'h08
    } dbg_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_BUS,
        ST_WAIT_HALT,
        ST_DONE
    } dbg_state_t;

    localparam logic [DATA_W-1:0] RSP_ILLEGAL     = 32'hBAD0_0000;
    localparam logic [DATA_W-1:0] RSP_NOT_HALTED  = 32'hBAD0_0001;
    localparam logic [DATA_W-1:0] RSP_BUS_TIMEOUT = 32'hDEAD_BEEF;

endpackage

// File: rtl/dbg_cmd_responder.sv
// Debug command responder: four-phase host handshake driving core halt/reset, memory bus and register file.
// Optional bus timeout enabled with DBG_BUS_TIMEOUT_EN.
module dbg_cmd_responder
    import dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              sys_clk_i,
    input  logic              rstn_i,
    input  logic [CMD_W-1:0]  dbg_cmd_i,
    input  logic [DATA_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_data_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic              dbg_ready_o,
    output logic              halt_o,
    input  logic              halted_i,
    output logic              core_rst_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [DATA_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [RF_AW-1:0]  rf_addr_o,
    output logic              rf_we_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [DATA_W-1:0] rf_rdata_i
);

    dbg_state_t        state_q;
    logic [CMD_W-1:0]  cmd_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ok_q;
    logic [DATA_W-1:0] data_q;
    logic              ready_q;
    logic              halt_q;
    logic              core_rst_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [DATA_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic [RF_AW-1:0]  rf_addr_q;
    logic              rf_we_q;
    logic [DATA_W-1:0] rf_wdata_q;

`ifdef DBG_BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
`else
    logic [31:0] unused_timeout_c;
    assign unused_timeout_c = 32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ok_q        <= 1'b0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            halt_q      <= 1'b0;
            core_rst_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rf_addr_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_wdata_q  <= '0;
`ifdef DBG_BUS_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            core_rst_q <= 1'b0;
            rf_we_q    <= 1'b0;
            case (state_q)
                // Latch the command; one-cycle side effects are launched here so they land in EXEC.
                ST_IDLE: begin
                    if (dbg_cmd_i != CMD_NOP) begin
                        cmd_q   <= dbg_cmd_i;
                        addr_q  <= dbg_addr_i;
                        wdata_q <= dbg_data_i;
                        ok_q    <= halted_i;
                        state_q <= ST_EXEC;
                        if (dbg_cmd_i == CMD_RESET) begin
                            core_rst_q <= 1'b1;
                        end
                        if (dbg_cmd_i == CMD_REG_RD || dbg_cmd_i == CMD_REG_WR) begin
                            rf_addr_q  <= dbg_addr_i[RF_AW-1:0];
                            rf_wdata_q <= dbg_data_i;
                            rf_we_q    <= (dbg_cmd_i == CMD_REG_WR) && halted_i;
                        end
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_DONE;
                    ready_q <= 1'b1;
                    case (cmd_q)
                        CMD_HALT: begin
                            halt_q  <= 1'b1;
                            data_q  <= '0;
                            ready_q <= 1'b0;
                            state_q <= ST_WAIT_HALT;
                        end
                        CMD_RESUME: begin
                            halt_q <= 1'b0;
                            data_q <= '0;
                        end
                        CMD_STEP: begin
                            halt_q  <= 1'b0;
                            data_q  <= '0;
                            ready_q <= 1'b0;
                            state_q <= ST_WAIT_HALT;
                        end
                        CMD_RESET: begin
                            data_q <= '0;
                        end
                        CMD_MEM_RD, CMD_MEM_WR: begin
                            if (ok_q) begin
                                bus_req_q   <= 1'b1;
                                bus_we_q    <= (cmd_q == CMD_MEM_WR);
                                bus_addr_q  <= addr_q;
                                bus_wdata_q <= wdata_q;
                                ready_q     <= 1'b0;
                                state_q     <= ST_BUS;
`ifdef DBG_BUS_TIMEOUT_EN
                                tmo_q       <= '0;
`endif
                            end else begin
                                data_q <= RSP_NOT_HALTED;
                            end
                        end
                        CMD_REG_RD: begin
                            data_q <= ok_q ? rf_rdata_i : RSP_NOT_HALTED;
                        end
                        CMD_REG_WR: begin
                            data_q <= ok_q ? wdata_q : RSP_NOT_HALTED;
                        end
                        default: begin
                            data_q <= RSP_ILLEGAL;
                        end
                    endcase
                end
                ST_BUS: begin
                    if (bus_ack_i) begin
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        data_q    <= bus_we_q ? bus_wdata_q : bus_rdata_i;
                        ready_q   <= 1'b1;
                        state_q   <= ST_DONE;
                    end
`ifdef DBG_BUS_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        data_q    <= RSP_BUS_TIMEOUT;
                        ready_q   <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                // A STEP arrives here with halt low; re-raise it before trusting halted_i.
                ST_WAIT_HALT: begin
                    if (!halt_q) begin
                        halt_q <= 1'b1;
                    end else if (halted_i) begin
                        ready_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (dbg_cmd_i == CMD_NOP) begin
                        ready_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_data_o  = data_q;
    assign dbg_ready_o = ready_q;
    assign halt_o      = halt_q;
    assign core_rst_o  = core_rst_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign rf_addr_o   = rf_addr_q;
    assign rf_we_o     = rf_we_q;
    assign rf_wdata_o  = rf_wdata_q;

endmodule

// File: doc/dbg_cmd_responder.md
DBG_CMD_RESPONDER -- requirements
Module: dbg_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, giving the bus-timeout limit in cycles (used only with DBG_BUS_TIMEOUT_EN).
REQ-002 SHALL have ports: sys_clk_i  in  1  single clock; rstn_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: dbg_cmd_i  in  8  command, 0x00 = NOP; dbg_addr_i  in  32  address or register index; dbg_data_i  in  32  write data.
REQ-004 SHALL have ports: dbg_data_o  out  32  response data; dbg_ready_o  out  1  command complete.
REQ-005 SHALL have ports: halt_o  out  1  core halt request; halted_i  in  1  core reports halted; core_rst_o  out  1  one-cycle core reset pulse.
REQ-006 SHALL have ports: bus_req_o  out  1; bus_we_o  out  1; bus_addr_o  out  32; bus_wdata_o  out  32; bus_ack_i  in  1; bus_rdata_i  in  32 (rdata valid with ack).
REQ-007 SHALL have ports: rf_addr_o  out  5; rf_we_o  out  1; rf_wdata_o  out  32; rf_rdata_i  in  32 (combinational read).

Function
REQ-008 SHALL decode commands: 0x01 HALT, 0x02 RESUME, 0x03 RESET, 0x04 MEM_RD, 0x05 MEM_WR, 0x06 REG_RD, 0x07 REG_WR, 0x08 STEP; any other non-zero code is ILLEGAL.
REQ-009 SHALL implement a four-phase handshake: the host holds the command until dbg_ready_o=1, then drives NOP; dbg_ready_o stays 1 until NOP is seen, then drops in the next cycle.
REQ-010 SHALL use states IDLE, EXEC, BUS, WAIT_HALT, DONE; in IDLE, a non-NOP dbg_cmd_i latches cmd, addr and data and moves to EXEC in the next cycle.
REQ-011 SHALL ignore command, address and data inputs while not in IDLE; latched copies are used.
REQ-012 SHALL, for HALT: set halt_o=1, go to WAIT_HALT, and go to DONE when halted_i=1; dbg_data_o=0.
REQ-013 SHALL, for RESUME: clear halt_o and go to DONE in one cycle; dbg_data_o=0.
REQ-014 SHALL, for STEP: clear halt_o for exactly one cycle, then set it again, go to WAIT_HALT, and then go to DONE.
REQ-015 SHALL, for RESET: assert core_rst_o for exactly one cycle in EXEC, then go to DONE; halt_o is unchanged.
REQ-016 SHALL, for MEM_RD/MEM_WR: assert bus_req_o in BUS, held with stable addr/we/wdata until the cycle bus_ack_i=1; on ack, drop req next cycle; MEM_RD captures bus_rdata_i into dbg_data_o; go to DONE.
REQ-017 SHALL, for REG_RD/REG_WR: drive rf_addr_o=addr[4:0]; REG_RD captures rf_rdata_i; REG_WR pulses rf_we_o for one cycle; go to DONE in one cycle.
REQ-018 SHALL, for REG_*/MEM_* with halted_i=0, skip execution and return 0xBAD0_0001 in DONE.
REQ-019 SHALL, for ILLEGAL, go to DONE with dbg_data_o=0xBAD0_0000.
REQ-020 SHALL hold dbg_data_o stable from DONE until the next command is latched.
REQ-021 SHALL have latency of: REG/RESUME/RESET/ILLEGAL, latch to ready = 2 cycles; MEM = 2 + ack wait.

Reset
REQ-022 SHALL, on rstn_i=0, asynchronously force state IDLE, dbg_ready_o=0, dbg_data_o=0, halt_o=0, core_rst_o=0, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, rf_we_o=0, rf_addr_o=0, rf_wdata_o=0.
REQ-023 SHALL, if reset occurs mid-transaction, abandon the transaction with no replay; the bus slave must tolerate req dropping without ack.

Configuration
REQ-024 SHALL, with DBG_BUS_TIMEOUT_EN defined, abort BUS after TIMEOUT_CYCLES cycles without ack: drop bus_req_o, return 0xDEAD_BEEF, and go to DONE.
REQ-025 SHALL, without DBG_BUS_TIMEOUT_EN, wait indefinitely in BUS and synthesize no counter.

Structure
REQ-026 SHALL place the command codes (enum dbg_cmd_t), state enum and error constants (0xBAD0_0000, 0xBAD0_0001, 0xDEAD_BEEF) in shared package dbg_pkg.
REQ-027 SHALL be a single module, with no sub-modules.

Verification
REQ-028 SHALL test HALT with halted_i rising 3 cycles later: ready asserts 1 cycle after halted_i; halt_o=1; dbg_data_o=0.
REQ-029 SHALL test halted core, MEM_WR addr 0x100 data 0x1234_5678, ack after 4 cycles, then MEM_RD with rdata 0x1234_5678: ready on each, dbg_data_o=0x1234_5678, and bus_req_o stable until ack.
REQ-030 SHALL test REG_RD while not halted: dbg_data_o=0xBAD0_0001 and rf_we_o never high.
REQ-031 SHALL test cmd 0x7F: dbg_data_o=0xBAD0_0000; ready drops 1 cycle after NOP.
REQ-032 SHALL test, with DBG_BUS_TIMEOUT_EN, MEM_RD with no ack: dbg_data_o=0xDEAD_BEEF after 256 cycles.
REQ-033 SHALL test rstn_i low in the BUS state: all outputs reach reset values immediately, and a new HALT afterwards completes normally.
